// File: rtl/instr_loader.sv
// -----------------------------------------------------------------------------
// instr_loader
//   Front-panel program loader. Two successive Enter pulses supply the high and
//   then the low byte of a 16-bit instruction word. Each completed word is
//   written to instruction memory at an auto-incrementing address. Once every
//   location has been written the loader parks in a full state until Clear or
//   reset.
//
//   Optional feature macro: LOADER_CHECKSUM_EN
//     When defined, a 16-bit running sum of written words is kept and
//     exported on Checksum. When undefined, neither the port nor the
//     accumulator exists.
//
// Ports
//   Clk       in   system clock, rising edge
//   ResetN    in   synchronous active-low reset
//   Enter     in   one-cycle pulse, accept byte on Sw
//   Clear     in   one-cycle pulse, restart session at address 0
//   Sw        in   [7:0] byte being entered
//   Wr_En     out  memory write strobe, one cycle per word
//   Wr_Addr   out  [ADDR_W-1:0] current / write address
//   Wr_Data   out  [15:0] assembled word {hi, lo}
//   ByteSel   out  1 while waiting for the low byte
//   Count     out  [ADDR_W:0] words written since reset/Clear
//   Full      out  every location written; Enter ignored
//   Checksum  out  [15:0] running sum (LOADER_CHECKSUM_EN only)
// -----------------------------------------------------------------------------
module instr_loader #(
    parameter int ADDR_W = 8
) (
    input  logic              Clk,
    input  logic              ResetN,
    input  logic              Enter,
    input  logic              Clear,
    input  logic [7:0]        Sw,
    output logic              Wr_En,
    output logic [ADDR_W-1:0] Wr_Addr,
    output logic [15:0]       Wr_Data,
    output logic              ByteSel,
    output logic [ADDR_W:0]   Count,
`ifdef LOADER_CHECKSUM_EN
    output logic [15:0]       Checksum,
`endif
    output logic              Full
);

    typedef enum logic [1:0] {
        S_HI    = 2'd0,
        S_LO    = 2'd1,
        S_WRITE = 2'd2,
        S_FULL  = 2'd3
    } state_t;

    state_t            state;
    logic [7:0]        hi_q;
    logic [ADDR_W-1:0] addr_q;
    logic [15:0]       data_q;
    logic [ADDR_W:0]   count_q;
`ifdef LOADER_CHECKSUM_EN
    logic [15:0]       csum_q;
`endif

    always_ff @(posedge Clk) begin
        if (!ResetN) begin
            state   <= S_HI;
            hi_q    <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            count_q <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum_q  <= '0;
`endif
        end else if (Clear) begin
            // Clear beats Enter. A write already on the bus this cycle still
            // lands in memory, but it is not counted. Wr_Data is left alone.
            state   <= S_HI;
            hi_q    <= '0;
            addr_q  <= '0;
            count_q <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum_q  <= '0;
`endif
        end else begin
            case (state)
                S_HI: begin
                    if (Enter) begin
                        hi_q  <= Sw;
                        state <= S_LO;
                    end
                end
                S_LO: begin
                    if (Enter) begin
                        data_q <= {hi_q, Sw};
                        state  <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    // Enter is ignored here. Wr_En is high for this one cycle.
                    count_q <= count_q + 1'b1;
`ifdef LOADER_CHECKSUM_EN
                    csum_q  <= csum_q + data_q;
`endif
                    addr_q  <= addr_q + 1'b1;   // wraps to 0 after the last slot
                    state   <= (&addr_q) ? S_FULL : S_HI;
                end
                S_FULL: begin
                    // parked until Clear or reset
                end
                default: state <= S_HI;
            endcase
        end
    end

    // All outputs come from registers or are decoded from registered state.
    assign Wr_En    = (state == S_WRITE);
    assign ByteSel  = (state == S_LO);
    assign Full     = (state == S_FULL);
    assign Wr_Addr  = addr_q;
    assign Wr_Data  = data_q;
    assign Count    = count_q;
`ifdef LOADER_CHECKSUM_EN
    assign Checksum = csum_q;
`endif

endmodule

// File: tb/tb_instr_loader.sv
module tb_instr_loader;

    localparam int ADDR_W = 8;

    logic              Clk = 1'b0;
    logic              ResetN;
    logic              Enter;
    logic              Clear;
    logic [7:0]        Sw;
    logic              Wr_En;
    logic [ADDR_W-1:0] Wr_Addr;
    logic [15:0]       Wr_Data;
    logic              ByteSel;
    logic [ADDR_W:0]   Count;
    logic              Full;
`ifdef LOADER_CHECKSUM_EN
    logic [15:0]       Checksum;
`endif

    int vectors = 0;
    int errors  = 0;

    instr_loader #(.ADDR_W(ADDR_W)) dut (
        .Clk      (Clk),
        .ResetN   (ResetN),
        .Enter    (Enter),
        .Clear    (Clear),
        .Sw       (Sw),
        .Wr_En    (Wr_En),
        .Wr_Addr  (Wr_Addr),
        .Wr_Data  (Wr_Data),
        .ByteSel  (ByteSel),
        .Count    (Count),
`ifdef LOADER_CHECKSUM_EN
        .Checksum (Checksum),
`endif
        .Full     (Full)
    );

    always #5 Clk = ~Clk;

    // Stimulus helpers: every call starts and ends 1 time unit after a rising
    // edge, so outputs read right after a call reflect that edge.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic enter_byte(input logic [7:0] b);
        Enter = 1'b1;
        Sw    = b;
        tick();
        Enter = 1'b0;
    endtask

    task automatic pulse_clear();
        Clear = 1'b1;
        tick();
        Clear = 1'b0;
    endtask

    task automatic test_reset();
        ResetN = 1'b0;
        Clear  = 1'b0;
        Sw     = 8'hFF;
        Enter  = 1'b1;
        tick();
        vectors++;
        if (Wr_En !== 1'b0) begin errors++; $display("FAIL reset_wren_c1 got %b want 0", Wr_En); end
        Enter = 1'b0;
        tick();
        Enter = 1'b1;
        tick();
        Enter = 1'b0;
        vectors++;
        if ({Wr_En, Wr_Addr, Wr_Data, ByteSel, Count, Full} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got en=%b addr=%h data=%h bs=%b cnt=%0d full=%b want all 0",
                     Wr_En, Wr_Addr, Wr_Data, ByteSel, Count, Full);
        end
`ifdef LOADER_CHECKSUM_EN
        vectors++;
        if (Checksum !== 16'h0) begin errors++; $display("FAIL reset_checksum got %h want 0000", Checksum); end
`endif
        ResetN = 1'b1;
        tick();
        vectors++;
        if (ByteSel !== 1'b0 || Wr_En !== 1'b0) begin
            errors++; $display("FAIL reset_release got bs=%b en=%b want 0 0", ByteSel, Wr_En);
        end
    endtask

    task automatic test_single_word();
        enter_byte(8'h12);
        vectors++;
        if (ByteSel !== 1'b1 || Wr_En !== 1'b0) begin
            errors++; $display("FAIL single_hi got bs=%b en=%b want 1 0", ByteSel, Wr_En);
        end
        enter_byte(8'h34);
        vectors++;
        if (Wr_En !== 1'b1 || Wr_Addr !== 8'h00 || Wr_Data !== 16'h1234) begin
            errors++; $display("FAIL single_write got en=%b addr=%h data=%h want 1 00 1234", Wr_En, Wr_Addr, Wr_Data);
        end
        tick();
        vectors++;
        if (Wr_En !== 1'b0 || Count !== 9'd1 || Wr_Addr !== 8'h01 || ByteSel !== 1'b0 || Wr_Data !== 16'h1234) begin
            errors++; $display("FAIL single_after got en=%b cnt=%0d addr=%h bs=%b data=%h want 0 1 01 0 1234",
                               Wr_En, Count, Wr_Addr, ByteSel, Wr_Data);
        end
`ifdef LOADER_CHECKSUM_EN
        vectors++;
        if (Checksum !== 16'h1234) begin errors++; $display("FAIL single_checksum got %h want 1234", Checksum); end
`endif
    endtask

    // Enter during the write cycle is dropped; the next word starts clean.
    task automatic test_back_to_back();
        enter_byte(8'hA1);
        enter_byte(8'hB2);
        enter_byte(8'hC3);           // lands in S_WRITE
        vectors++;
        if (ByteSel !== 1'b0 || Wr_En !== 1'b0 || Count !== 9'd2 || Wr_Addr !== 8'h02) begin
            errors++; $display("FAIL b2b_drop got bs=%b en=%b cnt=%0d addr=%h want 0 0 2 02", ByteSel, Wr_En, Count, Wr_Addr);
        end
        enter_byte(8'hD4);
        enter_byte(8'hE5);
        vectors++;
        if (Wr_En !== 1'b1 || Wr_Addr !== 8'h02 || Wr_Data !== 16'hD4E5) begin
            errors++; $display("FAIL b2b_write got en=%b addr=%h data=%h want 1 02 D4E5", Wr_En, Wr_Addr, Wr_Data);
        end
        tick();
    endtask

    task automatic test_fill();
        int bad = 0;
        pulse_clear();
        for (int i = 0; i < 256; i++) begin
            enter_byte(8'h00);
            enter_byte(8'(i));
            if (Wr_En !== 1'b1 || Wr_Addr !== 8'(i) || Wr_Data !== 16'(i)) bad++;
            tick();
        end
        vectors++;
        if (bad != 0) begin errors++; $display("FAIL fill_writes got %0d bad write cycles want 0", bad); end
        vectors++;
        if (Full !== 1'b1 || Count !== 9'd256 || Wr_Addr !== 8'h00 || ByteSel !== 1'b0) begin
            errors++; $display("FAIL fill_full got full=%b cnt=%0d addr=%h bs=%b want 1 256 00 0", Full, Count, Wr_Addr, ByteSel);
        end
`ifdef LOADER_CHECKSUM_EN
        vectors++;
        if (Checksum !== 16'h7F80) begin errors++; $display("FAIL fill_checksum got %h want 7F80", Checksum); end
`endif
        enter_byte(8'h5A);
        enter_byte(8'hA5);
        vectors++;
        if (Wr_En !== 1'b0 || ByteSel !== 1'b0) begin
            errors++; $display("FAIL full_ignore got en=%b bs=%b want 0 0", Wr_En, ByteSel);
        end
        tick();
        vectors++;
        if (Full !== 1'b1 || Count !== 9'd256 || Wr_En !== 1'b0 || Wr_Data !== 16'h00FF) begin
            errors++; $display("FAIL full_hold got full=%b cnt=%0d en=%b data=%h want 1 256 0 00FF", Full, Count, Wr_En, Wr_Data);
        end
    endtask

    task automatic test_clear_full();
        pulse_clear();
        vectors++;
        if (Full !== 1'b0 || Count !== 9'd0 || Wr_Addr !== 8'h00 || ByteSel !== 1'b0) begin
            errors++; $display("FAIL clrfull_state got full=%b cnt=%0d addr=%h bs=%b want 0 0 00 0", Full, Count, Wr_Addr, ByteSel);
        end
`ifdef LOADER_CHECKSUM_EN
        vectors++;
        if (Checksum !== 16'h0) begin errors++; $display("FAIL clrfull_checksum got %h want 0000", Checksum); end
`endif
        enter_byte(8'h55);
        enter_byte(8'h66);
        vectors++;
        if (Wr_En !== 1'b1 || Wr_Addr !== 8'h00 || Wr_Data !== 16'h5566) begin
            errors++; $display("FAIL clrfull_write got en=%b addr=%h data=%h want 1 00 5566", Wr_En, Wr_Addr, Wr_Data);
        end
        tick();
    endtask

    task automatic test_clear_midword();
        pulse_clear();
        enter_byte(8'hAB);
        pulse_clear();
        vectors++;
        if (ByteSel !== 1'b0) begin errors++; $display("FAIL clrmid_bytesel got %b want 0", ByteSel); end
        enter_byte(8'h01);
        enter_byte(8'h02);
        vectors++;
        if (Wr_En !== 1'b1 || Wr_Addr !== 8'h00 || Wr_Data !== 16'h0102) begin
            errors++; $display("FAIL clrmid_write got en=%b addr=%h data=%h want 1 00 0102", Wr_En, Wr_Addr, Wr_Data);
        end
        tick();
        vectors++;
        if (Count !== 9'd1 || Wr_Addr !== 8'h01) begin
            errors++; $display("FAIL clrmid_count got cnt=%0d addr=%h want 1 01", Count, Wr_Addr);
        end
    endtask

    task automatic test_clear_enter_same();
        pulse_clear();
        enter_byte(8'h11);
        Clear = 1'b1;
        enter_byte(8'h22);
        Clear = 1'b0;
        vectors++;
        if (Wr_En !== 1'b0 || ByteSel !== 1'b0 || Count !== 9'd0) begin
            errors++; $display("FAIL clr_enter got en=%b bs=%b cnt=%0d want 0 0 0", Wr_En, ByteSel, Count);
        end
        tick();
        vectors++;
        if (Wr_En !== 1'b0) begin errors++; $display("FAIL clr_enter_next got en=%b want 0", Wr_En); end
    endtask

    task automatic test_clear_in_write();
        enter_byte(8'h77);
        enter_byte(8'h88);
        vectors++;
        if (Wr_En !== 1'b1 || Wr_Data !== 16'h7788) begin
            errors++; $display("FAIL clrwr_write got en=%b data=%h want 1 7788", Wr_En, Wr_Data);
        end
        pulse_clear();
        vectors++;
        if (Wr_En !== 1'b0 || Count !== 9'd0 || Wr_Addr !== 8'h00) begin
            errors++; $display("FAIL clrwr_after got en=%b cnt=%0d addr=%h want 0 0 00", Wr_En, Count, Wr_Addr);
        end
`ifdef LOADER_CHECKSUM_EN
        vectors++;
        if (Checksum !== 16'h0) begin errors++; $display("FAIL clrwr_checksum got %h want 0000", Checksum); end
`endif
    endtask

    task automatic test_reset_in_write();
        enter_byte(8'h01);
        enter_byte(8'h02);
        ResetN = 1'b0;
        tick();
        ResetN = 1'b1;
        vectors++;
        if (Wr_En !== 1'b0 || Count !== 9'd0 || Wr_Addr !== 8'h00 || Wr_Data !== 16'h0000) begin
            errors++; $display("FAIL rstwr got en=%b cnt=%0d addr=%h data=%h want 0 0 00 0000", Wr_En, Count, Wr_Addr, Wr_Data);
        end
    endtask

    initial begin
        Enter = 1'b0;
        Clear = 1'b0;
        Sw    = 8'h00;
        ResetN = 1'b0;
        #1;
        test_reset();
        test_single_word();
        test_back_to_back();
        test_fill();
        test_clear_full();
        test_clear_midword();
        test_clear_enter_same();
        test_clear_in_write();
        test_reset_in_write();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/instr_loader.md
# instr_loader

Front-panel program loader for the DE2 processor build: assembles 16-bit instruction words from two successive 8-bit switch entries, one per Enter pulse, and writes each completed word into the processor's instruction memory at an auto-incrementing address. It is the writer side of the instruction-memory port that the Processor reads from. It sits between the ButtonSync/KeyFilter pulse chain and the memory write port, and its status outputs feed the board's hex/LED display path.

## Interface
- ADDR_W, 8, instruction-memory address width; depth = 2**ADDR_W words
- Clk  in  1  system clock; all state changes on rising edge
- ResetN  in  1  synchronous, active-low reset
- Enter  in  1  single-cycle pulse (already debounced/edge-filtered) accepting the byte on Sw
- Clear  in  1  single-cycle pulse restarting the load session at address 0
- Sw  in  8  byte being entered
- Wr_En  out  1  memory write strobe, one cycle per completed word
- Wr_Addr  out  ADDR_W  write address, valid while Wr_En=1
- Wr_Data  out  16  write data {high byte, low byte}, valid while Wr_En=1
- ByteSel  out  1  0 = expecting high byte, 1 = expecting low byte
- Count  out  ADDR_W+1  number of words written since reset/Clear
- Full  out  1  all 2**ADDR_W locations written; further Enter ignored
- Checksum  out  16  running modulo-2^16 sum of written words (LOADER_CHECKSUM_EN only)

## Operation
- States: S_HI, S_LO, S_WRITE, S_FULL. Reset state S_HI.
- S_HI: Enter -> capture Sw into hi register, go S_LO.
- S_LO: Enter -> Wr_Data <= {hi, Sw}, go S_WRITE.
- S_WRITE: Wr_En=1 for exactly this cycle at current address; next edge Count+1, Checksum += Wr_Data; if address = 2**ADDR_W-1 go S_FULL with address wrapped to 0, else address+1 and go S_HI. Enter in S_WRITE is dropped.
- S_FULL: Full=1; Enter ignored; only Clear or reset leaves.
- Clear (any state): next state S_HI, address 0, Count 0, Checksum 0, hi register 0; a pending high byte is discarded. A Clear in S_WRITE still lets that cycle's write complete at the memory (Wr_En already high) but Count/Checksum are cleared, not incremented.
- Clear and Enter in the same cycle: Clear wins, Enter dropped.
- ByteSel = 1 only in S_LO.
- Wr_Addr holds the current address in every state; Wr_Data holds last assembled word outside S_WRITE.
- Count saturates naturally at 2**ADDR_W (reaches exactly 256 for ADDR_W=8); address is ADDR_W bits and wraps.

## Timing
- Reset values: state S_HI, Wr_En 0, Wr_Addr 0, Wr_Data 0, ByteSel 0, Count 0, Full 0, Checksum 0, hi register 0.
- All outputs registered or decoded from registered state; no combinational path from inputs to outputs.
- Second Enter at edge N -> Wr_En high during cycle N+1 -> Count/Wr_Addr update visible at N+2.
- Minimum 2 cycles between accepted Enters across a word boundary (S_WRITE costs one cycle); KeyFilter spacing guarantees this in practice.
- ResetN low at any edge, including during S_WRITE, overrides everything; Wr_En is 0 the cycle after.

## Configuration
- LOADER_CHECKSUM_EN defined: Checksum port, 16-bit accumulator, update in S_WRITE, clear on reset/Clear.
- Not defined: Checksum port and accumulator absent; all other behaviour identical.

## Test plan
- Reset: hold ResetN=0 two cycles with Enter pulsing -> all outputs at reset values, no Wr_En.
- Single word: Enter Sw=0x12, Enter Sw=0x34 -> one-cycle Wr_En, Wr_Addr=0x00, Wr_Data=0x1234; then Count=1, Wr_Addr=0x01, ByteSel=0, Checksum=0x1234.
- Fill: 256 words of data=index -> Full=1, Count=256, Wr_Addr=0x00, Checksum=0x7F80; extra Enter pair -> no Wr_En, state unchanged.
- Clear mid-word: Enter Sw=0xAB, Clear, Enter Sw=0x01, Enter Sw=0x02 -> write 0x0102 at address 0, Count=1.
- Clear and Enter same cycle in S_LO -> no write, ByteSel=0, Count=0; Clear from S_FULL -> Full=0, next word written at address 0.
- Build without LOADER_CHECKSUM_EN: single-word scenario passes, no Checksum port elaborated.
